accel_host_issuer: RTL and testbench

ACCEL_HOST_ISSUER -- requirements
Module: accel_host_issuer

---
 rtl/accel_pkg.sv | 19 +
 rtl/sync_fifo.sv | 51 +++++
 rtl/accel_host_issuer.sv | 122 ++++++++++++
 tb/tb_accel_host_issuer.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared constants and types for the host-side accelerator issuer.
// Holds instruction/result widths, the READ opcode and the NOP word.
package accel_pkg;

    localparam int INSTR_W  = 64;
    localparam int RESULT_W = 32;

    localparam logic [3:0] OP_READ = 4'hE;

    typedef logic [INSTR_W-1:0]  instr_t;
    typedef logic [RESULT_W-1:0] result_t;

    localparam instr_t NOP_WORD = '0;

    function automatic logic is_read(input instr_t word);
        return word[INSTR_W-1 -: 4] == OP_READ;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO with wrap-bit pointers.
// pop_data reads zero while empty so downstream sees a clean idle word.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot a full push needs
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign count    = wr_ptr - rd_ptr;
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/accel_host_issuer.sv
// Queues host instructions, issues them to the accelerator one per cycle,
// and captures READ results into a credit-limited result FIFO.
module accel_host_issuer
    import accel_pkg::*;
#(
    parameter int CMD_DEPTH = 8,
    parameter int RES_DEPTH = 4,
    parameter int RD_LAT    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INSTR_W-1:0]  cmd_data,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    output logic [INSTR_W-1:0]  accel_instr,
    output logic                accel_instr_valid,
    input  logic                accel_buffer_full,
    input  logic [RESULT_W-1:0] accel_result,
    output logic [RESULT_W-1:0] res_data,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                busy
);

    localparam int CW = $clog2(CMD_DEPTH) + 1;
    localparam int RW = $clog2(RES_DEPTH) + 1;

    logic [CW-1:0] cmd_count;
    logic          cmd_empty;
    instr_t        cmd_head;
    logic          cmd_push;
    logic          head_read;
    logic          credit_ok;
    logic          issue;

    logic [RW-1:0] res_count;
    logic [RW-1:0] in_flight;
    logic          res_empty;
    logic          res_pop;
    logic          capture;

    logic [RD_LAT:1] pend;

    assign cmd_ready = cmd_count < CW'(CMD_DEPTH);
    assign cmd_push  = cmd_valid && cmd_ready;

    // Outstanding reads plus stored results may never exceed the FIFO size
    assign head_read = is_read(cmd_head);
    assign credit_ok = ({1'b0, in_flight} + {1'b0, res_count})
                       < (RW+1)'(RES_DEPTH);
    assign issue     = !cmd_empty && !accel_buffer_full &&
                       (!head_read || credit_ok);

    assign capture   = pend[RD_LAT];
    assign res_valid = !res_empty;
    assign res_pop   = res_valid && res_ready;

    assign busy = !cmd_empty || (in_flight != '0) ||
                  (pend != '0) || !res_empty;

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cmd_push),
        .push_data (cmd_data),
        .pop       (issue),
        .pop_data  (cmd_head),
        .count     (cmd_count),
        .empty     (cmd_empty)
    );

    sync_fifo #(
        .WIDTH (RESULT_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .push_data (accel_result),
        .pop       (res_pop),
        .pop_data  (res_data),
        .count     (res_count),
        .empty     (res_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accel_instr       <= NOP_WORD;
            accel_instr_valid <= 1'b0;
        end else if (issue) begin
            accel_instr       <= cmd_head;
            accel_instr_valid <= 1'b1;
        end else begin
            accel_instr       <= NOP_WORD;
            accel_instr_valid <= 1'b0;
        end
    end

    // Token enters on the cycle after the strobe, exits RD_LAT cycles after it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend <= '0;
        end else begin
            pend[1] <= accel_instr_valid && is_read(accel_instr);
            for (int i = 2; i <= RD_LAT; i++) begin
                pend[i] <= pend[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight <= '0;
        end else begin
            in_flight <= in_flight + RW'(issue && head_read) - RW'(capture);
        end
    end

endmodule

// File: tb/tb_accel_host_issuer.sv
// Directed self-checking bench for accel_host_issuer.
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_accel_host_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] accel_instr;
    logic        accel_instr_valid;
    logic        accel_buffer_full;
    logic [31:0] accel_result;
    logic [31:0] res_data;
    logic        res_valid;
    logic        res_ready;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int issue_cnt = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && accel_instr_valid) issue_cnt++;
    end

    accel_host_issuer #(
        .CMD_DEPTH (8),
        .RES_DEPTH (4),
        .RD_LAT    (6)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cmd_data          (cmd_data),
        .cmd_valid         (cmd_valid),
        .cmd_ready         (cmd_ready),
        .accel_instr       (accel_instr),
        .accel_instr_valid (accel_instr_valid),
        .accel_buffer_full (accel_buffer_full),
        .accel_result      (accel_result),
        .res_data          (res_data),
        .res_valid         (res_valid),
        .res_ready         (res_ready),
        .busy              (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready);
        end
        tests++;
        if (accel_instr !== 64'h0) begin
            fails++;
            $display("FAIL reset_instr: got %h want 0", accel_instr);
        end
        tests++;
        if (accel_instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_valid: got %0b want 0", accel_instr_valid);
        end
        tests++;
        if (res_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_res_data: got %h want 0", res_data);
        end
        tests++;
        if (res_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_res_valid: got %0b want 0", res_valid);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: got %0b want 0", busy);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_issue_order();
        logic [63:0] w [3];
        w[0] = 64'h1000_0000_0000_0001;
        w[1] = 64'h1000_0000_0000_0002;
        w[2] = 64'h1000_0000_0000_0003;
        cmd_valid = 1'b1;
        cmd_data  = w[0];
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) cmd_data = w[i+1];
            else cmd_valid = 1'b0;
            tick();
            tests++;
            if (accel_instr_valid !== 1'b1 || accel_instr !== w[i]) begin
                fails++;
                $display("FAIL issue_order[%0d]: got v=%0b %h want v=1 %h",
                         i, accel_instr_valid, accel_instr, w[i]);
            end
        end
        tick();
        tests++;
        if (accel_instr_valid !== 1'b0 || accel_instr !== 64'h0) begin
            fails++;
            $display("FAIL issue_idle: got v=%0b %h want v=0 0",
                     accel_instr_valid, accel_instr);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL issue_busy_clear: got %0b want 0", busy);
        end
    endtask

    task automatic test_buffer_full();
        logic seen;
        accel_buffer_full = 1'b1;
        cmd_valid = 1'b1;
        cmd_data  = 64'h2000_0000_0000_00A1;
        tick();
        cmd_data  = 64'h2000_0000_0000_00A2;
        tick();
        cmd_valid = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            if (accel_instr_valid) seen = 1'b1;
            tick();
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL full_block: got strobe=%0b want 0", seen);
        end
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL full_busy: got %0b want 1", busy);
        end
        accel_buffer_full = 1'b0;
        tick();
        tests++;
        if (accel_instr_valid !== 1'b1 ||
            accel_instr !== 64'h2000_0000_0000_00A1) begin
            fails++;
            $display("FAIL full_resume0: got v=%0b %h want v=1 ..A1",
                     accel_instr_valid, accel_instr);
        end
        tick();
        tests++;
        if (accel_instr_valid !== 1'b1 ||
            accel_instr !== 64'h2000_0000_0000_00A2) begin
            fails++;
            $display("FAIL full_resume1: got v=%0b %h want v=1 ..A2",
                     accel_instr_valid, accel_instr);
        end
        tick();
        tests++;
        if (accel_instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL full_no_dup: got %0b want 0", accel_instr_valid);
        end
    endtask

    task automatic test_full_same_cycle();
        cmd_valid = 1'b1;
        cmd_data  = 64'h2000_0000_0000_00C7;
        tick();
        cmd_valid = 1'b0;
        accel_buffer_full = 1'b1;
        tick();
        tests++;
        if (accel_instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL rise_block: got %0b want 0", accel_instr_valid);
        end
        accel_buffer_full = 1'b0;
        tick();
        tests++;
        if (accel_instr_valid !== 1'b1 ||
            accel_instr !== 64'h2000_0000_0000_00C7) begin
            fails++;
            $display("FAIL rise_issue: got v=%0b %h want v=1 ..C7",
                     accel_instr_valid, accel_instr);
        end
        tick();
        tests++;
        if (accel_instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL rise_no_dup: got %0b want 0", accel_instr_valid);
        end
    endtask

    task automatic test_read_latency();
        accel_result = 32'hDEAD_BEEF;
        cmd_valid = 1'b1;
        cmd_data  = 64'hE000_0000_0000_00A5;
        tick();
        cmd_valid = 1'b0;
        tick();
        tests++;
        if (accel_instr_valid !== 1'b1 ||
            accel_instr !== 64'hE000_0000_0000_00A5) begin
            fails++;
            $display("FAIL read_issue: got v=%0b %h want v=1 E..A5",
                     accel_instr_valid, accel_instr);
        end
        repeat (5) tick();
        tests++;
        if (res_valid !== 1'b0) begin
            fails++;
            $display("FAIL read_early_k5: got %0b want 0", res_valid);
        end
        tick();
        accel_result = 32'hCAFE_0001;
        tests++;
        if (res_valid !== 1'b0) begin
            fails++;
            $display("FAIL read_early_k6: got %0b want 0", res_valid);
        end
        tick();
        accel_result = 32'hDEAD_BEEF;
        tests++;
        if (res_valid !== 1'b1 || res_data !== 32'hCAFE_0001) begin
            fails++;
            $display("FAIL read_capture: got v=%0b %h want v=1 cafe0001",
                     res_valid, res_data);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tests++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL read_pop: got v=%0b busy=%0b want 0 0",
                     res_valid, busy);
        end
    endtask

    task automatic test_read_credit();
        int base;
        int pops;
        base = issue_cnt;
        res_ready = 1'b0;
        accel_result = 32'h0000_0A00;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cmd_data = 64'hE000_0000_0000_0010 + 64'(i);
            tick();
        end
        cmd_valid = 1'b0;
        repeat (20) tick();
        tests++;
        if (issue_cnt - base !== 4) begin
            fails++;
            $display("FAIL credit_issued: got %0d want 4", issue_cnt - base);
        end
        tests++;
        if (res_valid !== 1'b1 || res_data !== 32'h0000_0A00 ||
            busy !== 1'b1) begin
            fails++;
            $display("FAIL credit_held: got v=%0b %h busy=%0b want 1 a00 1",
                     res_valid, res_data, busy);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tests++;
        if (accel_instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL credit_return_lat: got %0b want 0",
                     accel_instr_valid);
        end
        tick();
        tests++;
        if (accel_instr_valid !== 1'b1 ||
            accel_instr !== 64'hE000_0000_0000_0014) begin
            fails++;
            $display("FAIL credit_fifth: got v=%0b %h want v=1 E..14",
                     accel_instr_valid, accel_instr);
        end
        repeat (10) tick();
        pops = 0;
        res_ready = 1'b1;
        repeat (10) begin
            if (res_valid) pops++;
            tick();
        end
        res_ready = 1'b0;
        tests++;
        if (pops !== 4 || busy !== 1'b0) begin
            fails++;
            $display("FAIL credit_drain: got pops=%0d busy=%0b want 4 0",
                     pops, busy);
        end
    endtask

    task automatic test_cmd_full();
        int n;
        int bad;
        accel_buffer_full = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cmd_data = 64'h2000_0000_0000_0020 + 64'(i);
            tick();
        end
        tests++;
        if (cmd_ready !== 1'b0) begin
            fails++;
            $display("FAIL cmd_full_ready: got %0b want 0", cmd_ready);
        end
        cmd_data = 64'h2000_0000_0000_0099;
        tick();
        cmd_valid = 1'b0;
        accel_buffer_full = 1'b0;
        n = 0;
        bad = 0;
        repeat (14) begin
            tick();
            if (accel_instr_valid) begin
                if (n >= 8 || accel_instr !== 64'h2000_0000_0000_0020 + 64'(n))
                    bad++;
                n++;
            end
        end
        tests++;
        if (n !== 8 || bad !== 0) begin
            fails++;
            $display("FAIL cmd_full_drain: got n=%0d bad=%0d want 8 0",
                     n, bad);
        end
        tests++;
        if (cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL cmd_full_recover: got %0b want 1", cmd_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        int base;
        accel_result = 32'h0000_7777;
        cmd_valid = 1'b1;
        cmd_data  = 64'hE000_0000_0000_0051;
        tick();
        cmd_data  = 64'hE000_0000_0000_0052;
        tick();
        cmd_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        tests++;
        if (accel_instr_valid !== 1'b0 || accel_instr !== 64'h0) begin
            fails++;
            $display("FAIL rst_mid_instr: got v=%0b %h want 0 0",
                     accel_instr_valid, accel_instr);
        end
        tests++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || cmd_ready !== 1'b1 ||
            res_data !== 32'h0) begin
            fails++;
            $display("FAIL rst_mid_flags: got busy=%0b rv=%0b cr=%0b rd=%h want 0 0 1 0",
                     busy, res_valid, cmd_ready, res_data);
        end
        tick();
        rst = 1'b0;
        accel_result = 32'h5555_5555;
        base = issue_cnt;
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (res_valid || busy) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0 || issue_cnt !== base) begin
            fails++;
            $display("FAIL rst_mid_discard: got seen=%0b issues=%0d want 0 0",
                     seen, issue_cnt - base);
        end
        rst = 1'b1;
        cmd_valid = 1'b1;
        cmd_data = 64'h3000_0000_0000_0031;
        tick();
        rst = 1'b0;
        tick();
        cmd_valid = 1'b0;
        tests++;
        if (accel_instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL first_issue_early: got %0b want 0",
                     accel_instr_valid);
        end
        tick();
        tests++;
        if (accel_instr_valid !== 1'b1 ||
            accel_instr !== 64'h3000_0000_0000_0031) begin
            fails++;
            $display("FAIL first_issue: got v=%0b %h want v=1 3..31",
                     accel_instr_valid, accel_instr);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        cmd_data = 64'h0;
        cmd_valid = 1'b0;
        accel_buffer_full = 1'b0;
        accel_result = 32'h0;
        res_ready = 1'b0;
        test_reset();
        test_issue_order();
        test_buffer_full();
        test_full_same_cycle();
        test_read_latency();
        test_read_credit();
        test_cmd_full();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
